calc_core: RTL and testbench
============================

Name: calc_core

Overview:
- Four-function-calculator datapath core, add-only in this revision.
- Sits between the button sanitizer and the screen driver.
- Holds the display register (D) and the upper/operand register (U), and runs the key-sequence FSM.
- Contains a serial BCD adder; D feeds the screen driver.

Parameters:
NUM_DIGITS, 8 (calc_pkg::NumDigits), number of BCD digits in D and U.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  reset; synchronous, active-high.
new_input_i  in  1  one-cycle pulse: active_button_i holds a newly pressed key.
active_button_i  in  calc_pkg::active_button_t  key: B_NUM_0..B_NUM_9, B_OP_ADD, B_OP_EQ, B_NONE.
display_o  out  calc_pkg::num_t  D register; significand[NUM_DIGITS-1] is the ones digit; all non-significand fields driven 0.
upper_o  out  calc_pkg::num_t  U register, same format.
busy_o  out  1  high while the adder runs; low means FSM state is IDLE.

Behaviour:
- Reset: D=0, U=0, busy_o=0.
  - Internal state: op_pending=0, first_eq=0, last_key=NONE, state=IDLE.
- Keys are accepted only in IDLE on a new_input_i pulse. A pulse while busy_o=1 is dropped.
- B_NONE and unlisted codes are ignored; no state change, last_key unchanged.
- Digit key k (D, U update on the next edge; busy_o stays 0):
  - last_key=DIGIT: D := D*10 + k (shift one BCD digit toward MSD, k into the ones digit); MSD overflow is discarded.
  - last_key=OP: U := D, then D := k.
  - last_key=NONE or EQ: D := k; U unchanged.
  - Then last_key := DIGIT.
- B_OP_ADD:
  - op_pending := 1, first_eq := 1, last_key := OP.
  - D and U unchanged; no add is performed.
- B_OP_EQ:
  - If op_pending=0: no change except last_key := EQ.
  - Otherwise start the add S = D + U and go to ADD.
    - If first_eq=1, capture old D into U when the add completes; first_eq := 0.
    - If first_eq=0, U is kept (repeat-equals uses the same operand).
  - last_key := EQ; op_pending remains set.
- ADD state:
  - busy_o=1 from the cycle after acceptance for exactly NUM_DIGITS cycles.
  - One BCD digit is added per cycle, ones digit first, with a carry register; a digit sum >9 subtracts 10 and sets carry.
  - On the last cycle: D := S, U is updated per first_eq, state := IDLE, busy_o := 0.
  - Carry out of the MSD is discarded, so the result wraps mod 10^NUM_DIGITS.
- Operands are latched at acceptance. D and U show their old values until the commit edge.
- Reset asserted mid-add aborts the add; all state returns to reset values on that edge.
- Outputs are registered; display_o and upper_o change only on commit or key edges.

Test Plan:
- Each sequence starts from reset. D is listed after each key, with busy_o waited low before the next key.
- 1,+,=,=,=,=,= -> D 1,1,1,2,3,4,5; U after last key = 1.
- 3,=,1,+,=,= -> D 3,3,1,1,1,2; U stays 0 until the first "=" after "+", then 1.
- +,3,=,1,+,=,=,=,=,= -> D 0,3,3,1,1,4,5,6,7,8; U 0,0,3,3,3,1,1,1,1,1.
- 1,+,1,=,+,=,+,=,+,=,+ -> D 1,1,1,2,2,3,3,5,5,8,8 (Fibonacci).
- 1,=,=,=,=,= -> D stays 1 (no pending op); busy_o never asserts. Digit entry 9,9,9,9,9,9,9,9,+,1,= -> D 0 (wrap).
- Timing and robustness:
  - busy_o is high for exactly 8 cycles per accepted "=".
  - Key pulses during busy are ignored.
  - Reset mid-add gives D=U=0 and busy_o=0 on the next edge.

Source files
------------

// File: rtl/calc_core.sv
// calc_core: key-sequence FSM, display/upper registers and a serial BCD adder
// for the calculator datapath. The add runs one digit per cycle, ones digit
// first, and commits the full result to D on its final cycle.

package calc_pkg;
   localparam int NumDigits = 8;

   typedef enum logic [3:0] {
      B_NUM_0  = 4'd0,
      B_NUM_1  = 4'd1,
      B_NUM_2  = 4'd2,
      B_NUM_3  = 4'd3,
      B_NUM_4  = 4'd4,
      B_NUM_5  = 4'd5,
      B_NUM_6  = 4'd6,
      B_NUM_7  = 4'd7,
      B_NUM_8  = 4'd8,
      B_NUM_9  = 4'd9,
      B_OP_ADD = 4'd10,
      B_OP_EQ  = 4'd11,
      B_NONE   = 4'd15
   } active_button_t;

   typedef logic [3:0] digit_t;

   // significand[0] is the most significant digit, significand[NumDigits-1]
   // the ones digit.
   typedef struct packed {
      logic                        sign;
      logic                        overflow;
      logic [2:0]                  dp_pos;
      digit_t [NumDigits-1:0]      significand;
   } num_t;
endpackage

// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a key; digit/op/eq keys update D, U and flags
// S_ADD  | serial BCD add of latched operands, one digit per cycle
module calc_core #(
   parameter int NUM_DIGITS = calc_pkg::NumDigits
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     new_input_i,
   input  calc_pkg::active_button_t active_button_i,
   output calc_pkg::num_t           display_o,
   output calc_pkg::num_t           upper_o,
   output logic                     busy_o
);
   import calc_pkg::*;

   localparam int CntW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef digit_t [NUM_DIGITS-1:0] reg_t;

   typedef enum logic {
      S_IDLE,
      S_ADD
   } state_t;

   typedef enum logic [1:0] {
      LK_NONE,
      LK_DIGIT,
      LK_OP,
      LK_EQ
   } last_key_t;

   state_t    state_q, state_d;
   last_key_t last_key_q, last_key_d;
   reg_t      d_q, d_d;
   reg_t      u_q, u_d;
   reg_t      opa_q, opa_d;
   reg_t      opb_q, opb_d;
   reg_t      sum_q, sum_d;
   logic      op_pending_q, op_pending_d;
   logic      first_eq_q, first_eq_d;
   logic      cap_u_q, cap_u_d;
   logic      carry_q, carry_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [3:0] key_code;
   logic [4:0] digit_raw;
   digit_t     digit_sum;
   logic       carry_out;
   reg_t       sum_upd;

   // One BCD digit of the running add, selected by the down-counter.
   always_comb begin
      digit_raw = {1'b0, opa_q[cnt_q]} + {1'b0, opb_q[cnt_q]} + {4'b0000, carry_q};
      if (digit_raw > 5'd9) begin
         digit_sum = 4'(digit_raw - 5'd10);
         carry_out = 1'b1;
      end else begin
         digit_sum = digit_raw[3:0];
         carry_out = 1'b0;
      end
      sum_upd        = sum_q;
      sum_upd[cnt_q] = digit_sum;
   end

   // Key decode, next-state and register updates.
   always_comb begin
      state_d      = state_q;
      last_key_d   = last_key_q;
      d_d          = d_q;
      u_d          = u_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      sum_d        = sum_q;
      op_pending_d = op_pending_q;
      first_eq_d   = first_eq_q;
      cap_u_d      = cap_u_q;
      carry_d      = carry_q;
      cnt_d        = cnt_q;
      key_code     = active_button_i;

      case (state_q)
         S_IDLE: begin
            if (new_input_i) begin
               if (key_code <= 4'd9) begin
                  case (last_key_q)
                     LK_DIGIT: d_d = {key_code, d_q[NUM_DIGITS-1:1]};
                     LK_OP: begin
                        u_d = d_q;
                        d_d = '0;
                        d_d[NUM_DIGITS-1] = key_code;
                     end
                     default: begin
                        d_d = '0;
                        d_d[NUM_DIGITS-1] = key_code;
                     end
                  endcase
                  last_key_d = LK_DIGIT;
               end else if (active_button_i == B_OP_ADD) begin
                  op_pending_d = 1'b1;
                  first_eq_d   = 1'b1;
                  last_key_d   = LK_OP;
               end else if (active_button_i == B_OP_EQ) begin
                  last_key_d = LK_EQ;
                  if (op_pending_q) begin
                     opa_d      = d_q;
                     opb_d      = u_q;
                     sum_d      = '0;
                     carry_d    = 1'b0;
                     cap_u_d    = first_eq_q;
                     first_eq_d = 1'b0;
                     cnt_d      = CntW'(NUM_DIGITS - 1);
                     state_d    = S_ADD;
                  end
               end
            end
         end
         S_ADD: begin
            sum_d   = sum_upd;
            carry_d = carry_out;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               // Carry out of the MSD is dropped: result wraps.
               d_d     = sum_upd;
               if (cap_u_q) begin
                  u_d = opa_q;
               end
               carry_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         last_key_q   <= LK_NONE;
         d_q          <= '0;
         u_q          <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         sum_q        <= '0;
         op_pending_q <= 1'b0;
         first_eq_q   <= 1'b0;
         cap_u_q      <= 1'b0;
         carry_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_key_q   <= last_key_d;
         d_q          <= d_d;
         u_q          <= u_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         sum_q        <= sum_d;
         op_pending_q <= op_pending_d;
         first_eq_q   <= first_eq_d;
         cap_u_q      <= cap_u_d;
         carry_q      <= carry_d;
         cnt_q        <= cnt_d;
      end
   end

   // Output formatting; only the significand carries information.
   always_comb begin
      display_o             = '0;
      display_o.significand = d_q;
      upper_o               = '0;
      upper_o.significand   = u_q;
      busy_o                = (state_q == S_ADD);
   end

endmodule

// File: tb/tb_calc_core.sv
// Bench for calc_core: a behavioural integer model predicts D, U and the busy
// length for each key; predictions are queued at drive time and compared once
// the DUT has settled back to idle.
module tb_calc_core;
   import calc_pkg::*;

   localparam int KADD  = 10;
   localparam int KEQ   = 11;
   localparam int KNONE = 15;
   localparam longint MODV = 64'd100000000;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           new_input_i = 1'b0;
   active_button_t active_button_i = B_NONE;
   num_t           display_o;
   num_t           upper_o;
   logic           busy_o;

   calc_core dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .new_input_i     (new_input_i),
      .active_button_i (active_button_i),
      .display_o       (display_o),
      .upper_o         (upper_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      longint d;
      longint u;
      int     busy;
   } exp_t;

   exp_t sb[$];

   // behavioural model state
   longint m_d, m_u;
   bit     m_op, m_fe;
   int     m_last;   // 0 none, 1 digit, 2 op, 3 eq

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic longint to_int(input num_t n);
      longint v = 0;
      for (int i = 0; i < NumDigits; i++) v = v * 10 + longint'(n.significand[i]);
      return v;
   endfunction

   task automatic model_reset();
      m_d = 0; m_u = 0; m_op = 0; m_fe = 0; m_last = 0;
   endtask

   task automatic model_key(input int k, output exp_t e);
      e.busy = 0;
      if (k >= 0 && k <= 9) begin
         if (m_last == 1) m_d = (m_d * 10 + k) % MODV;
         else if (m_last == 2) begin m_u = m_d; m_d = k; end
         else m_d = k;
         m_last = 1;
      end else if (k == KADD) begin
         m_op = 1; m_fe = 1; m_last = 2;
      end else if (k == KEQ) begin
         if (m_op) begin
            longint s;
            s = (m_d + m_u) % MODV;
            if (m_fe) begin m_u = m_d; m_fe = 0; end
            m_d = s;
            e.busy = 8;
         end
         m_last = 3;
      end
      e.d = m_d;
      e.u = m_u;
   endtask

   task automatic drive_pulse(input int k);
      new_input_i     = 1'b1;
      active_button_i = active_button_t'(4'(k));
      @(posedge clk_i); #1;
      new_input_i     = 1'b0;
      active_button_i = B_NONE;
   endtask

   task automatic compare_pop(input string tag, input int nbusy);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      check({tag, "_busy_cycles"}, nbusy, e.busy);
      check({tag, "_d"}, to_int(display_o), e.d);
      check({tag, "_u"}, to_int(upper_o), e.u);
      check({tag, "_flags"}, {display_o.sign, display_o.overflow, display_o.dp_pos,
                              upper_o.sign, upper_o.overflow, upper_o.dp_pos}, 0);
   endtask

   task automatic press(input int k, input string tag);
      exp_t e;
      int   n;
      model_key(k, e);
      sb.push_back(e);
      @(posedge clk_i); #1;
      drive_pulse(k);
      n = 0;
      while (busy_o && n < 40) begin
         @(posedge clk_i); #1;
         n++;
      end
      compare_pop(tag, n);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_d", to_int(display_o), 0);
      check("rst_u", to_int(upper_o), 0);
      check("rst_busy", longint'(busy_o), 0);
      rst_i = 1'b0;
      model_reset();
   endtask

   task automatic run_seq(input string name, input int keys[$]);
      do_reset();
      foreach (keys[i]) press(keys[i], $sformatf("%s_k%0d", name, i));
   endtask

   initial begin
      int q[$];
      exp_t e;
      int   n;

      model_reset();

      q = '{1, KADD, KEQ, KEQ, KEQ, KEQ, KEQ};
      run_seq("rep_eq", q);
      q = '{3, KEQ, 1, KADD, KEQ, KEQ};
      run_seq("eq_no_op", q);
      q = '{KADD, 3, KEQ, 1, KADD, KEQ, KEQ, KEQ, KEQ, KEQ};
      run_seq("op_first", q);
      q = '{1, KADD, 1, KEQ, KADD, KEQ, KADD, KEQ, KADD, KEQ, KADD};
      run_seq("fib", q);
      q = '{1, KEQ, KEQ, KEQ, KEQ, KEQ};
      run_seq("no_pending", q);
      q = '{9, 9, 9, 9, 9, 9, 9, 9, KADD, 1, KEQ};
      run_seq("wrap", q);
      q = '{1, KNONE, 2, 13, 3, 12, 4, 5, 6, 7, 8, 9};
      run_seq("ignore_shift", q);
      q = '{4, 5, KADD, 6, 7, KEQ, KEQ};
      run_seq("multi_digit", q);

      // key pulse during busy is dropped; D/U hold old values until commit
      do_reset();
      press(1, "busy_k0");
      press(KADD, "busy_k1");
      model_key(KEQ, e);
      sb.push_back(e);
      @(posedge clk_i); #1;
      drive_pulse(KEQ);
      n = 0;
      repeat (3) begin @(posedge clk_i); #1; n++; end
      check("busy_mid", longint'(busy_o), 1);
      check("busy_hold_d", to_int(display_o), 1);
      check("busy_hold_u", to_int(upper_o), 0);
      drive_pulse(7);
      n++;
      while (busy_o && n < 40) begin @(posedge clk_i); #1; n++; end
      compare_pop("busy_eq", n);
      press(2, "busy_after");

      // reset during the add aborts it on the same edge
      do_reset();
      press(5, "rmid_k0");
      press(KADD, "rmid_k1");
      @(posedge clk_i); #1;
      drive_pulse(KEQ);
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("rmid_d", to_int(display_o), 0);
      check("rmid_u", to_int(upper_o), 0);
      check("rmid_busy", longint'(busy_o), 0);
      rst_i = 1'b0;
      model_reset();
      press(KEQ, "rmid_eq");
      press(2, "rmid_digit");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
